mu01_mem_arbiter: RTL and testbench

- Two-port arbiter sharing the single-port 4096x16 MU01 program/data memory.
- Port 0 serves the MU01 core (fetch and LDA/STO/ADD/SUB operand accesses); port 1 serves the debug/program loader.
- Round-robin arbitration with a registered memory command and one access per granted cycle.
- Synchronous-read memory; read data returns one cycle after the access.

---
 rtl/mu01_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mu01_mem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mu01_mem_arbiter.sv
// mu01_mem_arbiter
//   Two-port round-robin arbiter in front of the single-port 4096x16 MU01
//   program/data memory. Port 0 is the MU01 core, port 1 the debug/program
//   loader. One access per granted cycle, registered memory command,
//   synchronous-read memory (read data one cycle after the access).
//
//   Ports:
//     clk, reset_n                      clock, async active-low reset
//     reqN/weN/addrN/wdataN             port N request (held until gntN)
//     gntN                              high during port N's access cycle
//     rvalidN/rdataN                    port N read return (rdata 0 otherwise)
//     lock0/lock1                       bus lock (only with MU01_ARB_LOCK_EN)
//     mem_en/mem_we/mem_addr/mem_wdata  memory command
//     mem_rdata                         memory read data
//
//   Optional feature macro: MU01_ARB_LOCK_EN (bus lock with forced release
//   after LOCK_MAX consecutive locked grants).

module mu01_mem_arbiter #(
    parameter int AW = 12,
    parameter int DW = 16
`ifdef MU01_ARB_LOCK_EN
    , parameter int LOCK_MAX = 16
`endif
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
`ifdef MU01_ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [1:0]    rvalid_q;
    logic          cand0, cand1;

`ifdef MU01_ARB_LOCK_EN
    localparam int CW = ($clog2(LOCK_MAX + 1) > 5) ? $clog2(LOCK_MAX + 1) : 5;
    localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);

    logic          lk_act_q;
    logic          lk_own_q;
    logic [CW-1:0] lk_cnt_q;
    logic          lk_hold;
    logic          lk_sel;

    // Lock masks the other port until the counter reaches LOCK_MAX; at that
    // point one arbitration runs unlocked so the other port can get in.
    assign lk_hold = lk_act_q && (lk_cnt_q < LMAX);
    assign lk_sel  = owner_d ? lock1 : lock0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lk_act_q <= 1'b0;
            lk_own_q <= 1'b0;
            lk_cnt_q <= '0;
        end else if (state_d == BUSY) begin
            lk_act_q <= lk_sel;
            lk_own_q <= owner_d;
            if (!lk_sel)
                lk_cnt_q <= '0;
            else if (lk_cnt_q >= LMAX)
                lk_cnt_q <= CW'(1);   // first grant after a forced release
            else
                lk_cnt_q <= lk_cnt_q + CW'(1);
        end
    end
`endif

    // State register plus the registered memory command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            // Read return for the access happening in this cycle.
            rvalid_q[0] <= (state_q == BUSY) && !we_q && !owner_q;
            rvalid_q[1] <= (state_q == BUSY) && !we_q &&  owner_q;
            if (state_d == BUSY) begin
                last_q  <= owner_d;
                we_q    <= owner_d ? we1    : we0;
                addr_q  <= owner_d ? addr1  : addr0;
                wdata_q <= owner_d ? wdata1 : wdata0;
            end else begin
                we_q    <= 1'b0;
            end
        end
    end

    // Next-state: a request is consumed in the cycle its grant is high, so a
    // port with gnt high is not a candidate for the following cycle.
    always_comb begin
        cand0   = req0 & ~gnt0;
        cand1   = req1 & ~gnt1;
`ifdef MU01_ARB_LOCK_EN
        if (lk_hold) begin
            if (lk_own_q) cand0 = 1'b0;
            else          cand1 = 1'b0;
        end
`endif
        state_d = IDLE;
        owner_d = owner_q;
        if (cand0 && cand1) begin
            state_d = BUSY;
            owner_d = ~last_q;
        end else if (cand0) begin
            state_d = BUSY;
            owner_d = 1'b0;
        end else if (cand1) begin
            state_d = BUSY;
            owner_d = 1'b1;
        end
    end

    // Outputs.
    always_comb begin
        gnt0      = (state_q == BUSY) && !owner_q;
        gnt1      = (state_q == BUSY) &&  owner_q;
        mem_en    = (state_q == BUSY);
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        rvalid0   = rvalid_q[0];
        rvalid1   = rvalid_q[1];
        rdata0    = rvalid_q[0] ? mem_rdata : '0;
        rdata1    = rvalid_q[1] ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mu01_mem_arbiter.sv
// Directed bench for mu01_mem_arbiter with a behavioural 4096x16
// synchronous-read memory. Lock scenario only with MU01_ARB_LOCK_EN.

module tb_mu01_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0, we0, req1, we1;
    logic [11:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
`ifdef MU01_ARB_LOCK_EN
    logic        lock0, lock1;
`endif

    logic [15:0] mem [0:4095];

    int checks   = 0;
    int failures = 0;

    mu01_mem_arbiter #(
        .AW(12), .DW(16)
`ifdef MU01_ARB_LOCK_EN
        , .LOCK_MAX(4)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef MU01_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
`ifdef MU01_ARB_LOCK_EN
        lock0 = 0; lock1 = 0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        idle_inputs();
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        mem[0]    = 16'h8005;
        mem[5]    = 16'h1234;
        mem_rdata = 16'h0;
        reset_n   = 0;
        idle_inputs();

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_gnt",    {30'd0, gnt1, gnt0}, 32'h0);
        chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'h0);
        chk("rst_mem",    {mem_en, mem_we, 2'b0, mem_addr, mem_wdata}, 32'h0);
        reset_n = 1;

        // Single read from port 0.
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 12'h000;
        @(negedge clk);
        chk("rd_gnt",   {30'd0, gnt1, gnt0}, 32'h1);
        chk("rd_cmd",   {mem_en, mem_we, 2'b0, mem_addr}, {16'd0, 4'b1000, 12'h000});
        req0 = 0;
        @(negedge clk);
        chk("rd_rvalid", {30'd0, rvalid1, rvalid0}, 32'h1);
        chk("rd_rdata0", rdata0, 32'h8005);
        chk("rd_rdata1", rdata1, 32'h0);
        chk("rd_gnt_after", {30'd0, gnt1, gnt0}, 32'h0);

        // Both ports requesting from reset: strict alternation, port 0 first.
        do_reset();
        req0 = 1; addr0 = 12'h005; req1 = 1; addr1 = 12'h000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("alt_%0d", i), {30'd0, gnt1, gnt0}, (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i > 0)
                chk($sformatf("alt_rd_%0d", i),
                    {rvalid1, rvalid0, rdata0 | rdata1},
                    (i % 2 == 0) ? {2'b10, 16'h8005} : {2'b01, 16'h1234});
        end
        idle_inputs();

        // Port 1 writes 0xFFF, then port 0 reads it back.
        do_reset();
        req1 = 1; we1 = 1; addr1 = 12'hFFF; wdata1 = 16'h0009;
        @(negedge clk);
        chk("wr_gnt", {30'd0, gnt1, gnt0}, 32'h2);
        chk("wr_cmd", {mem_en, mem_we, 2'b0, mem_addr, mem_wdata}, {4'b1100, 12'hFFF, 16'h0009});
        req1 = 0; we1 = 0;
        req0 = 1; we0 = 0; addr0 = 12'hFFF;
        @(negedge clk);
        chk("wr_rd_gnt", {30'd0, gnt1, gnt0}, 32'h1);
        chk("wr_no_rvalid", {30'd0, rvalid1, rvalid0}, 32'h0);
        chk("wr_rd_we", {31'd0, mem_we}, 32'h0);
        req0 = 0;
        @(negedge clk);
        chk("wr_rd_data", {15'd0, rvalid0, rdata0}, {15'd0, 1'b1, 16'h0009});

        // Port 0 alone, held: granted every other cycle.
        do_reset();
        req0 = 1; addr0 = 12'h000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("solo_en_%0d", i), {30'd0, mem_en, gnt0}, (i % 2 == 0) ? 32'h3 : 32'h0);
        end
        idle_inputs();

        // Reset in the middle of a read access.
        do_reset();
        req0 = 1; addr0 = 12'h005;
        @(negedge clk);
        chk("mid_gnt", {30'd0, mem_en, gnt0}, 32'h3);
        req0 = 0;
        #1 reset_n = 0;
        #1;
        chk("mid_async", {29'd0, mem_en, gnt1, gnt0}, 32'h0);
        @(negedge clk);
        chk("mid_no_rvalid", {30'd0, rvalid1, rvalid0}, 32'h0);
        reset_n = 1;
        @(negedge clk);
        chk("mid_no_rvalid2", {30'd0, rvalid1, rvalid0}, 32'h0);
        req0 = 1; req1 = 1;
        @(negedge clk);
        chk("mid_first_tie", {30'd0, gnt1, gnt0}, 32'h1);
        idle_inputs();

`ifdef MU01_ARB_LOCK_EN
        // Port 1 locked with LOCK_MAX=4: 0=idle, 1=gnt0, 2=gnt1 per cycle.
        begin
            logic [1:0] lk_exp [0:14];
            lk_exp = '{2'd1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2,
                       2'd1, 2'd2, 2'd0, 2'd2, 2'd1, 2'd2, 2'd1};
            do_reset();
            req0 = 1; req1 = 1; lock1 = 1;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                chk($sformatf("lock_%0d", i), {30'd0, gnt1, gnt0}, {30'd0, lk_exp[i]});
                if (i == 10) lock1 = 0;
            end
            idle_inputs();
        end
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
